// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: scan-code constants, receiver FSM states and the
// direction bit indices used by the navigation and master state machines.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;

    localparam logic [7:0] PS2_UP    = 8'h75;
    localparam logic [7:0] PS2_RIGHT = 8'h74;
    localparam logic [7:0] PS2_DOWN  = 8'h72;
    localparam logic [7:0] PS2_LEFT  = 8'h6B;

    localparam logic [7:0] PS2_W     = 8'h1D;
    localparam logic [7:0] PS2_D     = 8'h23;
    localparam logic [7:0] PS2_S     = 8'h1B;
    localparam logic [7:0] PS2_A     = 8'h1C;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    typedef struct packed {
        logic       hit;
        logic [1:0] dir;
    } key_map_t;

    // Extended (E0-prefixed) arrow codes to direction bit index.
    function automatic key_map_t map_arrow(input logic [7:0] code);
        key_map_t m;
        m.hit = 1'b1;
        m.dir = DIR_UP;
        case (code)
            PS2_UP:    m.dir = DIR_UP;
            PS2_RIGHT: m.dir = DIR_RIGHT;
            PS2_DOWN:  m.dir = DIR_DOWN;
            PS2_LEFT:  m.dir = DIR_LEFT;
            default:   m.hit = 1'b0;
        endcase
        return m;
    endfunction

    function automatic key_map_t map_wasd(input logic [7:0] code);
        key_map_t m;
        m.hit = 1'b1;
        m.dir = DIR_UP;
        case (code)
            PS2_W:   m.dir = DIR_UP;
            PS2_D:   m.dir = DIR_RIGHT;
            PS2_S:   m.dir = DIR_DOWN;
            PS2_A:   m.dir = DIR_LEFT;
            default: m.hit = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: input synchronisers, clock glitch filter, 11-bit frame
// FSM with an inactivity timeout; emits received bytes and error pulses.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic          clk_meta, clk_sync;
    logic          data_meta, data_sync;
    logic          filt_level, filt_prev;
    logic [FW-1:0] filt_cnt;
    logic          fall_edge;

    rx_state_t     state, state_next;
    logic [2:0]    bit_cnt, bit_cnt_next;
    logic [7:0]    shift, shift_next;
    logic          perr_flag, perr_flag_next;
    logic [TW-1:0] to_cnt;
    logic          timeout_hit;

    logic          load_byte, valid_next, perr_next, ferr_next;

    // Both lines idle high, so the synchronisers reset to 1 to avoid a false edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            clk_meta  <= ps2_clk;
            clk_sync  <= clk_meta;
            data_meta <= ps2_data;
            data_sync <= data_meta;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            filt_level <= 1'b1;
            filt_prev  <= 1'b1;
            filt_cnt   <= '0;
        end else begin
            filt_prev <= filt_level;
            if (clk_sync == filt_level) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                filt_level <= clk_sync;
                filt_cnt   <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    assign fall_edge   = filt_prev & ~filt_level;
    assign timeout_hit = (state != RX_IDLE) && !fall_edge &&
                         (to_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            to_cnt <= '0;
        end else if (state == RX_IDLE || fall_edge || timeout_hit) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= RX_IDLE;
            bit_cnt   <= '0;
            shift     <= '0;
            perr_flag <= 1'b0;
        end else begin
            state     <= state_next;
            bit_cnt   <= bit_cnt_next;
            shift     <= shift_next;
            perr_flag <= perr_flag_next;
        end
    end

    // Bits arrive LSB first, so each new bit enters at the top and shifts down.
    always_comb begin
        state_next     = state;
        bit_cnt_next   = bit_cnt;
        shift_next     = shift;
        perr_flag_next = perr_flag;
        load_byte      = 1'b0;
        valid_next     = 1'b0;
        perr_next      = 1'b0;
        ferr_next      = 1'b0;

        if (timeout_hit) begin
            state_next   = RX_IDLE;
            bit_cnt_next = '0;
            ferr_next    = 1'b1;
        end else if (fall_edge) begin
            case (state)
                RX_IDLE: begin
                    if (!data_sync) begin
                        state_next     = RX_DATA;
                        bit_cnt_next   = '0;
                        perr_flag_next = 1'b0;
                    end
                end
                RX_DATA: begin
                    shift_next   = {data_sync, shift[7:1]};
                    bit_cnt_next = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_next = RX_PARITY;
                    end
                end
                RX_PARITY: begin
                    perr_flag_next = (data_sync != ~^shift);
                    state_next     = RX_STOP;
                end
                RX_STOP: begin
                    state_next = RX_IDLE;
                    if (!data_sync) begin
                        ferr_next = 1'b1;
                    end else if (perr_flag) begin
                        perr_next = 1'b1;
                    end else begin
                        load_byte  = 1'b1;
                        valid_next = 1'b1;
                    end
                end
                default: state_next = RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_byte    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            if (load_byte) begin
                rx_byte <= shift;
            end
            rx_valid   <= valid_next;
            parity_err <= perr_next;
            frame_err  <= ferr_next;
        end
    end

endmodule

// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard receiver mapping arrow keys onto a PUSH_BUTTONS-ordered vector.
// Define PS2_WASD_EN to also map the W/A/S/D keys onto the same bits.
module ps2_key_receiver
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    output logic [3:0] KEY_BUTTONS,
    output logic [7:0] SCAN_CODE,
    output logic       SCAN_VALID,
    output logic       PARITY_ERR,
    output logic       FRAME_ERR
);

    logic       ext, brk;
    key_map_t   arrow_map;
    logic       key_hit;
    logic [1:0] key_dir;

    ps2_frame_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_frame_rx (
        .clock      (CLOCK),
        .reset      (RESET),
        .ps2_clk    (PS2_CLK),
        .ps2_data   (PS2_DATA),
        .rx_byte    (SCAN_CODE),
        .rx_valid   (SCAN_VALID),
        .parity_err (PARITY_ERR),
        .frame_err  (FRAME_ERR)
    );

`ifdef PS2_WASD_EN
    key_map_t wasd_map;

    always_comb begin
        arrow_map = map_arrow(SCAN_CODE);
        wasd_map  = map_wasd(SCAN_CODE);
        key_hit   = ext && arrow_map.hit;
        key_dir   = arrow_map.dir;
        if (!ext && wasd_map.hit) begin
            key_hit = 1'b1;
            key_dir = wasd_map.dir;
        end
    end
`else
    always_comb begin
        arrow_map = map_arrow(SCAN_CODE);
        key_hit   = ext && arrow_map.hit;
        key_dir   = arrow_map.dir;
    end
`endif

    // Prefix bytes only arm flags; the next ordinary byte consumes them.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            ext         <= 1'b0;
            brk         <= 1'b0;
            KEY_BUTTONS <= '0;
        end else if (PARITY_ERR || FRAME_ERR) begin
            ext <= 1'b0;
            brk <= 1'b0;
        end else if (SCAN_VALID) begin
            if (SCAN_CODE == PS2_EXT) begin
                ext <= 1'b1;
            end else if (SCAN_CODE == PS2_BRK) begin
                brk <= 1'b1;
            end else begin
                if (key_hit) begin
                    KEY_BUTTONS[key_dir] <= ~brk;
                end
                ext <= 1'b0;
                brk <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Directed testbench for ps2_key_receiver: keyboard frames with hand-computed
// expected scan codes, error pulses and direction vectors.
module tb_ps2_key_receiver;

    localparam int TB_TIMEOUT = 2000;
    localparam int HALF       = 30;

    logic       CLOCK = 1'b0;
    logic       RESET;
    logic       PS2_CLK;
    logic       PS2_DATA;
    logic [3:0] KEY_BUTTONS;
    logic [7:0] SCAN_CODE;
    logic       SCAN_VALID;
    logic       PARITY_ERR;
    logic       FRAME_ERR;

    int checks = 0;
    int errors = 0;
    int validCount = 0;
    int parityCount = 0;
    int frameCount = 0;
    int v0, p0, f0;

    ps2_key_receiver #(
        .FILTER_LEN     (8),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .CLOCK       (CLOCK),
        .RESET       (RESET),
        .PS2_CLK     (PS2_CLK),
        .PS2_DATA    (PS2_DATA),
        .KEY_BUTTONS (KEY_BUTTONS),
        .SCAN_CODE   (SCAN_CODE),
        .SCAN_VALID  (SCAN_VALID),
        .PARITY_ERR  (PARITY_ERR),
        .FRAME_ERR   (FRAME_ERR)
    );

    always #5 CLOCK = ~CLOCK;

    always @(negedge CLOCK) begin
        if (SCAN_VALID) validCount++;
        if (PARITY_ERR) parityCount++;
        if (FRAME_ERR) frameCount++;
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic waitCycles(input int n);
        repeat (n) @(negedge CLOCK);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic snap();
        v0 = validCount;
        p0 = parityCount;
        f0 = frameCount;
    endtask

    // Data changes while the keyboard clock is high; glitch pulses land late in the high phase.
    task automatic sendBit(input logic b, input bit glitch);
        PS2_DATA = b;
        if (glitch) begin
            waitCycles(18);
            PS2_CLK = 1'b0;
            waitCycles(3);
            PS2_CLK = 1'b1;
            waitCycles(HALF - 21);
        end else begin
            waitCycles(HALF);
        end
        PS2_CLK = 1'b0;
        waitCycles(HALF);
        PS2_CLK = 1'b1;
    endtask

    task automatic applyStimulus(input logic [7:0] code, input bit badParity,
                                 input bit badStop, input bit glitch);
        logic par;
        par = (~^code) ^ badParity;
        sendBit(1'b0, glitch);
        for (int i = 0; i < 8; i++) sendBit(code[i], glitch);
        sendBit(par, glitch);
        sendBit(~badStop, glitch);
        PS2_DATA = 1'b1;
        waitCycles(40);
    endtask

    task automatic sendKey(input logic [7:0] code);
        applyStimulus(code, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        RESET    = 1'b1;
        PS2_CLK  = 1'b1;
        PS2_DATA = 1'b1;
        waitCycles(5);
        checkOutput("reset keys", 32'(KEY_BUTTONS), 32'h0);
        checkOutput("reset scan", 32'(SCAN_CODE), 32'h00);
        checkOutput("reset valid", 32'(SCAN_VALID), 32'h0);
        checkOutput("reset perr", 32'(PARITY_ERR), 32'h0);
        checkOutput("reset ferr", 32'(FRAME_ERR), 32'h0);
        RESET = 1'b0;
        waitCycles(5);

        snap();
        sendKey(8'hE0);
        checkOutput("E0 valid", 32'(validCount - v0), 32'd1);
        checkOutput("E0 scan", 32'(SCAN_CODE), 32'hE0);
        checkOutput("E0 keys", 32'(KEY_BUTTONS), 32'h0);
        snap();
        sendKey(8'h75);
        checkOutput("up valid", 32'(validCount - v0), 32'd1);
        checkOutput("up scan", 32'(SCAN_CODE), 32'h75);
        checkOutput("up make", 32'(KEY_BUTTONS), 32'b0001);

        snap();
        sendKey(8'hE0); sendKey(8'hF0); sendKey(8'h75);
        checkOutput("up break", 32'(KEY_BUTTONS), 32'b0000);
        checkOutput("up break scan", 32'(SCAN_CODE), 32'h75);
        checkOutput("up break valid", 32'(validCount - v0), 32'd3);

        sendKey(8'hE0); sendKey(8'h74);
        sendKey(8'hE0); sendKey(8'h6B);
        checkOutput("right+left", 32'(KEY_BUTTONS), 32'b1010);
        sendKey(8'hE0); sendKey(8'hF0); sendKey(8'h74);
        checkOutput("right break", 32'(KEY_BUTTONS), 32'b1000);

        snap();
        applyStimulus(8'h6B, 1'b1, 1'b0, 1'b0);
        checkOutput("bad parity perr", 32'(parityCount - p0), 32'd1);
        checkOutput("bad parity valid", 32'(validCount - v0), 32'd0);
        checkOutput("bad parity ferr", 32'(frameCount - f0), 32'd0);
        checkOutput("bad parity scan", 32'(SCAN_CODE), 32'h74);
        checkOutput("bad parity keys", 32'(KEY_BUTTONS), 32'b1000);

        snap();
        sendKey(8'hE0);
        applyStimulus(8'h6B, 1'b1, 1'b0, 1'b0);
        sendKey(8'h72);
        checkOutput("error clears ext", 32'(KEY_BUTTONS), 32'b1000);
        checkOutput("error clears ext scan", 32'(SCAN_CODE), 32'h72);
        checkOutput("error clears ext valid", 32'(validCount - v0), 32'd2);

        snap();
        applyStimulus(8'h6B, 1'b0, 1'b1, 1'b0);
        checkOutput("bad stop ferr", 32'(frameCount - f0), 32'd1);
        checkOutput("bad stop valid", 32'(validCount - v0), 32'd0);
        checkOutput("bad stop perr", 32'(parityCount - p0), 32'd0);
        checkOutput("bad stop scan", 32'(SCAN_CODE), 32'h72);

        snap();
        applyStimulus(8'h6B, 1'b1, 1'b1, 1'b0);
        checkOutput("both err ferr", 32'(frameCount - f0), 32'd1);
        checkOutput("both err perr", 32'(parityCount - p0), 32'd0);

        snap();
        sendBit(1'b0, 1'b0); sendBit(1'b1, 1'b0); sendBit(1'b0, 1'b0); sendBit(1'b1, 1'b0);
        PS2_DATA = 1'b1;
        waitCycles(TB_TIMEOUT + 100);
        checkOutput("timeout ferr", 32'(frameCount - f0), 32'd1);
        checkOutput("timeout valid", 32'(validCount - v0), 32'd0);
        snap();
        sendKey(8'hE0); sendKey(8'h72);
        checkOutput("after timeout keys", 32'(KEY_BUTTONS), 32'b1100);
        checkOutput("after timeout scan", 32'(SCAN_CODE), 32'h72);
        checkOutput("after timeout valid", 32'(validCount - v0), 32'd2);
        checkOutput("after timeout ferr", 32'(frameCount - f0), 32'd0);

        snap();
        PS2_CLK = 1'b0; waitCycles(3); PS2_CLK = 1'b1; waitCycles(20);
        applyStimulus(8'hE0, 1'b0, 1'b0, 1'b1);
        applyStimulus(8'hF0, 1'b0, 1'b0, 1'b1);
        applyStimulus(8'h72, 1'b0, 1'b0, 1'b1);
        checkOutput("glitch keys", 32'(KEY_BUTTONS), 32'b1000);
        checkOutput("glitch scan", 32'(SCAN_CODE), 32'h72);
        checkOutput("glitch valid", 32'(validCount - v0), 32'd3);
        checkOutput("glitch errs", 32'((frameCount - f0) + (parityCount - p0)), 32'd0);
        applyStimulus(8'hE0, 1'b0, 1'b0, 1'b1);
        applyStimulus(8'h75, 1'b0, 1'b0, 1'b1);
        checkOutput("glitch up make", 32'(KEY_BUTTONS), 32'b1001);

        sendBit(1'b0, 1'b0); sendBit(1'b1, 1'b1); sendBit(1'b1, 1'b0); sendBit(1'b0, 1'b0);
        RESET = 1'b1;
        PS2_DATA = 1'b1;
        waitCycles(3);
        RESET = 1'b0;
        waitCycles(2);
        checkOutput("mid reset keys", 32'(KEY_BUTTONS), 32'h0);
        checkOutput("mid reset scan", 32'(SCAN_CODE), 32'h00);
        waitCycles(10);
        snap();
        sendKey(8'hE0); sendKey(8'h75);
        checkOutput("post reset keys", 32'(KEY_BUTTONS), 32'b0001);
        checkOutput("post reset scan", 32'(SCAN_CODE), 32'h75);
        checkOutput("post reset valid", 32'(validCount - v0), 32'd2);
        checkOutput("post reset ferr", 32'(frameCount - f0), 32'd0);

        sendKey(8'hE0); sendKey(8'hF0); sendKey(8'h75);
        checkOutput("pre wasd keys", 32'(KEY_BUTTONS), 32'b0000);
        snap();
        sendKey(8'h1D);
        checkOutput("W valid", 32'(validCount - v0), 32'd1);
        checkOutput("W scan", 32'(SCAN_CODE), 32'h1D);
`ifdef PS2_WASD_EN
        checkOutput("W make", 32'(KEY_BUTTONS), 32'b0001);
`else
        checkOutput("W make", 32'(KEY_BUTTONS), 32'b0000);
`endif
        sendKey(8'h23);
`ifdef PS2_WASD_EN
        checkOutput("D make", 32'(KEY_BUTTONS), 32'b0011);
`else
        checkOutput("D make", 32'(KEY_BUTTONS), 32'b0000);
`endif
        sendKey(8'hF0); sendKey(8'h1D);
`ifdef PS2_WASD_EN
        checkOutput("W break", 32'(KEY_BUTTONS), 32'b0010);
`else
        checkOutput("W break", 32'(KEY_BUTTONS), 32'b0000);
`endif
        checkOutput("W break scan", 32'(SCAN_CODE), 32'h1D);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
